// File: rtl/nar_flop_bank_if.sv
`default_nettype none
// ============================================================================
// Module  : nar_flop_bank_if
// Brief   : Shared set/data inputs and the three lane outputs of nar_flop_bank.
// Revision: 1.0 - initial release
// ============================================================================
interface nar_flop_bank_if #(
  parameter int WIDTH = 1
);
  logic             set;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out_nas;
  logic [WIDTH-1:0] out_nss;
  logic [WIDTH-1:0] out_noset;

  modport master (
    output set,
    output in,
    input  out_nas,
    input  out_nss,
    input  out_noset
  );

  modport slave (
    input  set,
    input  in,
    output out_nas,
    output out_nss,
    output out_noset
  );
endinterface
`default_nettype wire

// File: rtl/nar_flop_bank.sv
`default_nettype none
// ============================================================================
// Module  : nar_flop_bank
// Brief   : Three D-flop lanes sharing clock, async reset, set and data:
//           async-set (NAS), sync-set (NSS) and no-set (NoSet).
// Revision: 1.0 - initial release
// ============================================================================
module nar_flop_bank #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic               clock,
  input  logic               reset,
  nar_flop_bank_if.slave     bus
);

  logic             w_set;
  logic [WIDTH-1:0] w_in;
  logic [WIDTH-1:0] r_nas;
  logic [WIDTH-1:0] r_nss;
  logic [WIDTH-1:0] r_noset;

  assign w_set = bus.set;
  assign w_in  = bus.in;

  // Set is an asynchronous control here: a falling set edge loads SET_VAL at
  // once, and a clock edge while set is still low keeps reloading it.
  always_ff @(posedge clock or negedge reset or negedge w_set) begin
    if (!reset) begin
      r_nas <= RST_VAL;
    end else if (!w_set) begin
      r_nas <= SET_VAL;
    end else begin
      r_nas <= w_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_nss <= RST_VAL;
    end else if (!w_set) begin
      r_nss <= SET_VAL;
    end else begin
      r_nss <= w_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_noset <= RST_VAL;
    end else begin
      r_noset <= w_in;
    end
  end

  assign bus.out_nas   = r_nas;
  assign bus.out_nss   = r_nss;
  assign bus.out_noset = r_noset;

endmodule
`default_nettype wire

// File: tb/tb_nar_flop_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_nar_flop_bank
// Brief   : Self-checking bench for nar_flop_bank with an event-level model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nar_flop_bank;

  localparam int            W    = 8;
  localparam logic [W-1:0]  SETV = 8'hA5;
  localparam logic [W-1:0]  RSTV = 8'h3C;

  logic clock;
  logic reset;
  nar_flop_bank_if #(.WIDTH(W)) bus ();

  nar_flop_bank #(.WIDTH(W), .SET_VAL(SETV), .RST_VAL(RSTV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected lane values, updated from the behavioural rules on each event.
  logic [W-1:0] exp_nas, exp_nss, exp_noset;

  task automatic drive_reset(input logic r);
    reset = r;
    if (!r) begin
      exp_nas = RSTV; exp_nss = RSTV; exp_noset = RSTV;
    end
    #1;
  endtask

  task automatic drive_set(input logic s);
    logic fell;
    fell = bus.set && !s;
    bus.set = s;
    if (fell && reset) exp_nas = SETV;
    #1;
  endtask

  task automatic drive_in(input logic [W-1:0] d);
    bus.in = d;
    #1;
  endtask

  // Rising clock edge: every lane samples, set only matters if it is low.
  task automatic step();
    @(posedge clock);
    if (reset) begin
      exp_noset = bus.in;
      exp_nss   = bus.set ? bus.in : SETV;
      exp_nas   = bus.set ? bus.in : SETV;
    end
    #1;
  endtask

  task automatic test_reset();
    drive_reset(1'b0);
    n_tests++;
    if ({bus.out_nas, bus.out_nss, bus.out_noset} !== {RSTV, RSTV, RSTV}) begin
      n_fail++;
      $display("FAIL reset_async: got %h/%h/%h want %h", bus.out_nas, bus.out_nss, bus.out_noset, RSTV);
    end
    step();
    n_tests++;
    if ({bus.out_nas, bus.out_nss, bus.out_noset} !== {RSTV, RSTV, RSTV}) begin
      n_fail++;
      $display("FAIL reset_hold: got %h/%h/%h want %h", bus.out_nas, bus.out_nss, bus.out_noset, RSTV);
    end
  endtask

  task automatic test_data_capture();
    drive_reset(1'b1);
    drive_in(8'hFF);
    n_tests++;
    if ({bus.out_nas, bus.out_nss, bus.out_noset} !== {RSTV, RSTV, RSTV}) begin
      n_fail++;
      $display("FAIL data_no_comb_path: got %h/%h/%h want %h", bus.out_nas, bus.out_nss, bus.out_noset, RSTV);
    end
    step();
    n_tests++;
    if ({bus.out_nas, bus.out_nss, bus.out_noset} !== {8'hFF, 8'hFF, 8'hFF}) begin
      n_fail++;
      $display("FAIL data_ones: got %h/%h/%h want ff", bus.out_nas, bus.out_nss, bus.out_noset);
    end
    drive_in(8'h00);
    step();
    n_tests++;
    if ({bus.out_nas, bus.out_nss, bus.out_noset} !== {8'h00, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL data_zeros: got %h/%h/%h want 00", bus.out_nas, bus.out_nss, bus.out_noset);
    end
  endtask

  task automatic test_set_style();
    drive_set(1'b0);
    n_tests++;
    if ({bus.out_nas, bus.out_nss, bus.out_noset} !== {SETV, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL set_async: got %h/%h/%h want %h/00/00", bus.out_nas, bus.out_nss, bus.out_noset, SETV);
    end
    step();
    n_tests++;
    if ({bus.out_nas, bus.out_nss, bus.out_noset} !== {SETV, SETV, 8'h00}) begin
      n_fail++;
      $display("FAIL set_sync: got %h/%h/%h want %h/%h/00", bus.out_nas, bus.out_nss, bus.out_noset, SETV, SETV);
    end
  endtask

  task automatic test_set_release();
    drive_set(1'b1);
    n_tests++;
    if ({bus.out_nas, bus.out_nss, bus.out_noset} !== {SETV, SETV, 8'h00}) begin
      n_fail++;
      $display("FAIL set_release_hold: got %h/%h/%h want %h/%h/00", bus.out_nas, bus.out_nss, bus.out_noset, SETV, SETV);
    end
    step();
    n_tests++;
    if ({bus.out_nas, bus.out_nss, bus.out_noset} !== {8'h00, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL set_release_load: got %h/%h/%h want 00", bus.out_nas, bus.out_nss, bus.out_noset);
    end
  endtask

  task automatic test_priority();
    drive_in(8'h5A);
    drive_reset(1'b0);
    drive_set(1'b0);
    n_tests++;
    if ({bus.out_nas, bus.out_nss, bus.out_noset} !== {RSTV, RSTV, RSTV}) begin
      n_fail++;
      $display("FAIL prio_reset_over_set: got %h/%h/%h want %h", bus.out_nas, bus.out_nss, bus.out_noset, RSTV);
    end
    drive_reset(1'b1);
    n_tests++;
    if ({bus.out_nas, bus.out_nss, bus.out_noset} !== {RSTV, RSTV, RSTV}) begin
      n_fail++;
      $display("FAIL prio_release_hold: got %h/%h/%h want %h", bus.out_nas, bus.out_nss, bus.out_noset, RSTV);
    end
    step();
    n_tests++;
    if ({bus.out_nas, bus.out_nss, bus.out_noset} !== {SETV, SETV, 8'h5A}) begin
      n_fail++;
      $display("FAIL prio_set_after_release: got %h/%h/%h want %h/%h/5a", bus.out_nas, bus.out_nss, bus.out_noset, SETV, SETV);
    end
    drive_set(1'b1);
  endtask

  task automatic test_reset_mid();
    drive_in(8'hFF);
    step();
    drive_reset(1'b0);
    n_tests++;
    if ({bus.out_nas, bus.out_nss, bus.out_noset} !== {RSTV, RSTV, RSTV}) begin
      n_fail++;
      $display("FAIL mid_reset_drop: got %h/%h/%h want %h", bus.out_nas, bus.out_nss, bus.out_noset, RSTV);
    end
    drive_reset(1'b1);
    drive_in(8'h96);
    step();
    n_tests++;
    if ({bus.out_nas, bus.out_nss, bus.out_noset} !== {8'h96, 8'h96, 8'h96}) begin
      n_fail++;
      $display("FAIL mid_reset_resume: got %h/%h/%h want 96", bus.out_nas, bus.out_nss, bus.out_noset);
    end
  endtask

  // One random asynchronous action per cycle, checked before and after the edge.
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int unsigned act;
      act = $urandom_range(0, 9);
      if (act < 5)       drive_in(W'($urandom));
      else if (act < 8)  drive_set(~bus.set);
      else if (act == 8) drive_reset(~reset);
      else if (!reset)   drive_reset(1'b1);
      n_tests++;
      if ({bus.out_nas, bus.out_nss, bus.out_noset} !== {exp_nas, exp_nss, exp_noset}) begin
        n_fail++;
        $display("FAIL rand_async[%0d]: got %h/%h/%h want %h/%h/%h", i,
                 bus.out_nas, bus.out_nss, bus.out_noset, exp_nas, exp_nss, exp_noset);
      end
      step();
      n_tests++;
      if ({bus.out_nas, bus.out_nss, bus.out_noset} !== {exp_nas, exp_nss, exp_noset}) begin
        n_fail++;
        $display("FAIL rand_edge[%0d]: got %h/%h/%h want %h/%h/%h", i,
                 bus.out_nas, bus.out_nss, bus.out_noset, exp_nas, exp_nss, exp_noset);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    bus.set = 1'b1;
    bus.in  = '0;
    exp_nas = 'x; exp_nss = 'x; exp_noset = 'x;
    #10;
    test_reset();
    test_data_capture();
    test_set_style();
    test_set_release();
    test_priority();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
